instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_if.sv | 36 +++
 rtl/instr_fetch_queue.sv | 86 ++++++++
 tb/tb_instr_fetch_queue.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_queue_if : fetch-to-decode instruction queue bus        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_pc;
    logic [31:0]              in_instr;
    logic                     in_compressed;
    logic                     in_pred;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic                     out_compressed;
    logic                     out_pred;
    logic [$clog2(DEPTH):0]   count;

    // Queue side
    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_compressed, in_pred, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_compressed, out_pred, count
    );

    // Fetch/decode side
    modport master (
        output flush, in_valid, in_pc, in_instr, in_compressed, in_pred, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_compressed, out_pred, count
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | instr_fetch_queue : circular FIFO between fetch and decode stages   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module instr_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    instr_fetch_queue_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          comp_q  [DEPTH];
    logic          pred_q  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          w_push;
    logic          w_pop;
    logic          w_out_valid;

    // in_ready depends only on registered occupancy
    assign bus.in_ready = (count_q < C_DEPTH);
    assign w_out_valid  = (count_q != '0);
    assign w_push       = bus.in_valid && bus.in_ready && !bus.flush;
    assign w_pop        = w_out_valid && bus.out_ready && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: natural pointer overflow is the modulo wrap
            if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            pc_q[wr_ptr_q]    <= bus.in_pc;
            instr_q[wr_ptr_q] <= bus.in_instr;
            comp_q[wr_ptr_q]  <= bus.in_compressed;
            pred_q[wr_ptr_q]  <= bus.in_pred;
        end
    end

    assign bus.out_valid      = w_out_valid;
    assign bus.count          = count_q;
    assign bus.out_pc         = w_out_valid ? pc_q[rd_ptr_q]    : 32'h0;
    assign bus.out_instr      = w_out_valid ? instr_q[rd_ptr_q] : 32'h0;
    assign bus.out_compressed = w_out_valid ? comp_q[rd_ptr_q]  : 1'b0;
    assign bus.out_pred       = w_out_valid ? pred_q[rd_ptr_q]  : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_instr_fetch_queue : vectors, corner sequences and random model   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    instr_fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
        logic        p;
    } ent_t;

    ent_t mq[$];

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] e_count;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic fl,
                         input logic [31:0] pc, input logic [31:0] instr,
                         input logic c, input logic p);
        bus.in_valid      = iv;
        bus.out_ready     = ordy;
        bus.flush         = fl;
        bus.in_pc         = pc;
        bus.in_instr      = instr;
        bus.in_compressed = c;
        bus.in_pred       = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: FIFO queue, decisions taken from the pre-edge occupancy
    task automatic model_step();
        bit   do_push, do_pop;
        ent_t e;
        if (bus.flush) begin
            mq.delete();
        end else begin
            do_pop  = (mq.size() != 0) && bus.out_ready;
            do_push = bus.in_valid && (mq.size() < DEPTH);
            e = '{pc: bus.in_pc, instr: bus.in_instr, c: bus.in_compressed, p: bus.in_pred};
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("rnd_count",  32'(bus.count), 32'(mq.size()));
        chk("rnd_in_rdy", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("rnd_valid",  32'(bus.out_valid), 32'(mq.size() != 0));
        chk("rnd_pc",     bus.out_pc, h.pc);
        chk("rnd_instr",  bus.out_instr, h.instr);
        chk("rnd_comp",   32'(bus.out_compressed), 32'(h.c));
        chk("rnd_pred",   32'(bus.out_pred), 32'(h.p));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            iv   ordy fl   pc          instr         cnt  vld  rdy  e_pc        e_instr
        vecs[0]  = '{1'b1,1'b0,1'b0,32'h0,      32'h00500093, 1,   1'b1,1'b1,32'h0,      32'h00500093};
        vecs[1]  = '{1'b1,1'b0,1'b0,32'h4,      32'h00A00113, 2,   1'b1,1'b1,32'h0,      32'h00500093};
        vecs[2]  = '{1'b0,1'b1,1'b0,32'h0,      32'h0,        1,   1'b1,1'b1,32'h4,      32'h00A00113};
        vecs[3]  = '{1'b1,1'b0,1'b0,32'h8,      32'h11,       2,   1'b1,1'b1,32'h4,      32'h00A00113};
        vecs[4]  = '{1'b1,1'b0,1'b0,32'hC,      32'h22,       3,   1'b1,1'b1,32'h4,      32'h00A00113};
        vecs[5]  = '{1'b1,1'b0,1'b0,32'h10,     32'h33,       4,   1'b1,1'b0,32'h4,      32'h00A00113};
        vecs[6]  = '{1'b1,1'b0,1'b0,32'h14,     32'h44,       4,   1'b1,1'b0,32'h4,      32'h00A00113};
        vecs[7]  = '{1'b1,1'b1,1'b0,32'h14,     32'h44,       3,   1'b1,1'b1,32'h8,      32'h11};
        vecs[8]  = '{1'b1,1'b0,1'b0,32'h14,     32'h44,       4,   1'b1,1'b0,32'h8,      32'h11};
        vecs[9]  = '{1'b0,1'b1,1'b0,32'h0,      32'h0,        3,   1'b1,1'b1,32'hC,      32'h22};
        vecs[10] = '{1'b1,1'b1,1'b1,32'h18,     32'h55,       0,   1'b0,1'b1,32'h0,      32'h0};
        vecs[11] = '{1'b0,1'b1,1'b0,32'h0,      32'h0,        0,   1'b0,1'b1,32'h0,      32'h0};
        vecs[12] = '{1'b0,1'b1,1'b0,32'h0,      32'h0,        0,   1'b0,1'b1,32'h0,      32'h0};
        vecs[13] = '{1'b0,1'b1,1'b0,32'h0,      32'h0,        0,   1'b0,1'b1,32'h0,      32'h0};
        vecs[14] = '{1'b1,1'b0,1'b0,32'h200,    32'h00001111, 1,   1'b1,1'b1,32'h200,    32'h00001111};
        vecs[15] = '{1'b0,1'b1,1'b0,32'h0,      32'h0,        0,   1'b0,1'b1,32'h0,      32'h0};

        reset_n = 1'b0;
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h1);
        chk("rst_instr", bus.out_instr, 32'h0);
        chk("rst_pc",    bus.out_pc, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc, vecs[i].instr, 0, 0);
            tick();
            chk($sformatf("vec%0d_count", i), 32'(bus.count), vecs[i].e_count);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_pc", i),    bus.out_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].e_instr);
        end

        // Continuous push+pop through the pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 32'h100 + 32'(2*i), 32'hA000 + 32'(i), 1'(i % 2), 1'(i % 3 == 0));
            tick();
            chk($sformatf("wrap%0d_count", i), 32'(bus.count), 32'h1);
            chk($sformatf("wrap%0d_pc", i),    bus.out_pc, 32'h100 + 32'(2*i));
            chk($sformatf("wrap%0d_instr", i), bus.out_instr, 32'hA000 + 32'(i));
            chk($sformatf("wrap%0d_comp", i),  32'(bus.out_compressed), 32'(i % 2));
            chk($sformatf("wrap%0d_pred", i),  32'(bus.out_pred), 32'(i % 3 == 0));
        end
        drive(0, 1, 0, 32'h0, 32'h0, 0, 0);
        tick();
        chk("wrap_drain_count", 32'(bus.count), 32'h0);

        mq.delete();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 31) == 0), $urandom, $urandom,
                  1'($urandom), 1'($urandom));
            model_step();
            tick();
            check_model();
        end

        // Asynchronous reset between edges with two entries queued
        drive(0, 0, 1, 32'h0, 32'h0, 0, 0);
        tick();
        drive(1, 0, 0, 32'h300, 32'hBEEF0001, 0, 0);
        tick();
        drive(1, 0, 0, 32'h304, 32'hBEEF0002, 0, 0);
        tick();
        chk("arst_pre_count", 32'(bus.count), 32'h2);
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_instr", bus.out_instr, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 0, 0, 32'h400, 32'h00001111, 1, 1);
        tick();
        chk("arst_push_instr", bus.out_instr, 32'h00001111);
        chk("arst_push_pc",    bus.out_pc, 32'h400);
        chk("arst_push_count", 32'(bus.count), 32'h1);
        drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
